aes_key_expand_wddl: RTL and testbench
======================================

AES_KEY_EXPAND_WDDL -- requirements
Module: aes_key_expand_wddl

Interface
REQ-001 SHALL provide one clock and an asynchronous, active-high reset; ports listed clock and reset first.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 kld  input  1  load-key strobe, sampled on clk.
REQ-005 key, key_n  input  128 each  cipher key, true and complement rails; key[127:96] maps to word 0.
REQ-006 next  input  1  advance-round request, sampled on clk.
REQ-007 w0, w1, w2, w3  output  32 each  round-key words, true rail; feed the add-round-key stage.
REQ-008 w0_n, w1_n, w2_n, w3_n  output  32 each  round-key words, complement rail.
REQ-009 round  output  4  index of the round key currently presented, 0..10.
REQ-010 valid  output  1  high only in EVAL; round-key rails are meaningful.
REQ-011 done  output  1  high in EVAL when round==10.
REQ-012 rail_err  output  1  sticky rail-mismatch flag; present only per REQ-032.

Function
REQ-013 The FSM SHALL have three states: IDLE, PRE (precharge), EVAL (evaluate).
REQ-014 PRE SHALL drive every bit of w0..w3 and w0_n..w3_n to 0, with valid=0.
REQ-015 EVAL SHALL drive complementary rails, w_n == ~w for all 128 bits, with valid=1.
REQ-016 IDLE SHALL drive all rails 0, with valid=0, done=0 and round unchanged.
REQ-017 kld high in any state: next state PRE; key/key_n captured into the working register; round cleared to 0.
REQ-018 Load latency: kld at edge t -> PRE during cycle t+1 -> EVAL with round=0 and w=key during cycle t+2.
REQ-019 next high in EVAL with round<10: next state PRE, then EVAL with round+1 and the next key-schedule words.
REQ-020 Each round advance SHALL take exactly 2 cycles: PRE, then EVAL.
REQ-021 next in PRE or IDLE SHALL be ignored, with no queuing.
REQ-022 next in EVAL with round==10 SHALL be ignored; state stays EVAL with done=1 until kld.
REQ-023 kld and next in the same cycle: kld wins; next is discarded.
REQ-024 A PRE state entered via next SHALL always proceed to EVAL on the following cycle.
REQ-025 Key schedule SHALL follow FIPS-197 for 128-bit keys:
- w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
- w1' = w1 ^ w0'
- w2' = w2 ^ w1'
- w3' = w3 ^ w2'
REQ-026 rcon for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36, held in a registered shift/lookup indexed by the next round.
REQ-027 SubWord SHALL use four byte S-box instances on the true rail.
REQ-028 The complement rail SHALL be computed by dual logic from the complement working register, never by inverting the output.
REQ-029 All XOR logic SHALL be bitwise, with no width extension.

Reset
REQ-030 While rst is high, and asynchronously on its assertion:
- state=IDLE, round=0, valid=0, done=0, rail_err=0
- all w/w_n rails = 0
- working registers = 0
REQ-031 Reset asserted mid-expansion SHALL abort the expansion; after release the block stays in IDLE until kld.

Configuration
REQ-032 Macro KEY_RAIL_CHECK_EN defined: in EVAL, any bit with w==w_n SHALL set rail_err the next cycle; rail_err stays set until rst or kld.
REQ-033 Macro KEY_RAIL_CHECK_EN undefined: no checker logic; rail_err is tied to 0.

Verification
REQ-034 rst pulse mid-round -> all outputs 0 immediately and state IDLE; next after release -> no change.
REQ-035 kld with key=2b7e151628aed2a6abf7158809cf4f3c -> cycle t+1: all rails 0; cycle t+2: valid=1, round=0, w0=2b7e1516, w0_n=d481eae9.
REQ-036 Same key, next ten times, each at EVAL:
- round 1: w0=a0fafe17
- round 10: w0..w3 = d014f9a8, c9ee2589, e13f0cc8, b6630ca6, with done=1
REQ-037 next at round 10 -> outputs unchanged; next in PRE -> ignored, single round advance only.
REQ-038 kld and next together at round 4 -> PRE, then round=0 with the new key.
REQ-039 With KEY_RAIL_CHECK_EN, force key_n bit 0 = key bit 0 and kld -> rail_err=1 one cycle after EVAL; it clears on the next kld with a proper key.

Source files
------------

// File: rtl/aes_key_expand_wddl_if.sv
// Dual-rail key-expansion bus: key load/advance controls in, WDDL round-key rails out.
interface aes_key_expand_wddl_if;
   logic         kld;
   logic [127:0] key;
   logic [127:0] key_n;
   logic         next;
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  w0_n, w1_n, w2_n, w3_n;
   logic [3:0]   round;
   logic         valid;
   logic         done;
   logic         rail_err;

   modport master (
      output kld, key, key_n, next,
      input  w0, w1, w2, w3, w0_n, w1_n, w2_n, w3_n, round, valid, done, rail_err
   );

   modport slave (
      input  kld, key, key_n, next,
      output w0, w1, w2, w3, w0_n, w1_n, w2_n, w3_n, round, valid, done, rail_err
   );
endinterface

// File: rtl/aes_key_expand_wddl.sv
// AES-128 key expansion with WDDL precharge/evaluate dual-rail round-key outputs.
// Optional rail mismatch checker enabled by macro KEY_RAIL_CHECK_EN.
//
// state | meaning
// IDLE  | after reset, rails 0, waiting for kld
// PRE   | precharge, all rails 0, next round key being settled
// EVAL  | evaluate, complementary rails valid for the current round
module aes_key_expand_wddl (
   input logic                   clk,
   input logic                   rst,
   aes_key_expand_wddl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, PRE, EVAL} state_t;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   // Complement-domain S-box: maps a complemented input byte to the complemented output byte.
   function automatic logic [7:0] sbox_dual(input logic [7:0] x_n);
      return ~SBOX[~x_n];
   endfunction

   state_t           state;
   logic [0:3][31:0] wk, wk_n;
   logic [0:3][31:0] nx, nx_n;
   logic [7:0]       rcon;
   logic [31:0]      rot, rot_n, sub, sub_n;
   logic [31:0]      rcon_w, rcon_w_n;

   assign rot      = {wk[3][23:0],   wk[3][31:24]};
   assign rot_n    = {wk_n[3][23:0], wk_n[3][31:24]};
   assign rcon_w   = {rcon, 24'h000000};
   assign rcon_w_n = {~rcon, 24'hffffff};

   always_comb begin
      sub   = '0;
      sub_n = '0;
      for (int i = 0; i < 4; i++) begin
         sub[8*i +: 8]   = SBOX[rot[8*i +: 8]];
         sub_n[8*i +: 8] = sbox_dual(rot_n[8*i +: 8]);
      end
   end

   // True rail uses XOR; complement rail uses the dual (XNOR for two terms, XOR of three complements).
   always_comb begin
      nx[0]   = wk[0] ^ sub ^ rcon_w;
      nx[1]   = wk[1] ^ nx[0];
      nx[2]   = wk[2] ^ nx[1];
      nx[3]   = wk[3] ^ nx[2];
      nx_n[0] = wk_n[0] ^ sub_n ^ rcon_w_n;
      nx_n[1] = ~(wk_n[1] ^ nx_n[0]);
      nx_n[2] = ~(wk_n[2] ^ nx_n[1]);
      nx_n[3] = ~(wk_n[3] ^ nx_n[2]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wk        <= '0;
         wk_n      <= '0;
         rcon      <= 8'h00;
         bus.round <= 4'd0;
         bus.valid <= 1'b0;
         bus.done  <= 1'b0;
         {bus.w0, bus.w1, bus.w2, bus.w3}         <= '0;
         {bus.w0_n, bus.w1_n, bus.w2_n, bus.w3_n} <= '0;
      end else if (bus.kld) begin
         state     <= PRE;
         wk        <= bus.key;
         wk_n      <= bus.key_n;
         rcon      <= 8'h01;
         bus.round <= 4'd0;
         bus.valid <= 1'b0;
         bus.done  <= 1'b0;
         {bus.w0, bus.w1, bus.w2, bus.w3}         <= '0;
         {bus.w0_n, bus.w1_n, bus.w2_n, bus.w3_n} <= '0;
      end else begin
         case (state)
            PRE: begin
               state     <= EVAL;
               bus.valid <= 1'b1;
               bus.done  <= (bus.round == 4'd10);
               {bus.w0, bus.w1, bus.w2, bus.w3}         <= wk;
               {bus.w0_n, bus.w1_n, bus.w2_n, bus.w3_n} <= wk_n;
            end
            EVAL: begin
               if (bus.next && bus.round != 4'd10) begin
                  state     <= PRE;
                  wk        <= nx;
                  wk_n      <= nx_n;
                  rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                  bus.round <= bus.round + 4'd1;
                  bus.valid <= 1'b0;
                  bus.done  <= 1'b0;
                  {bus.w0, bus.w1, bus.w2, bus.w3}         <= '0;
                  {bus.w0_n, bus.w1_n, bus.w2_n, bus.w3_n} <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               bus.valid <= 1'b0;
               bus.done  <= 1'b0;
               {bus.w0, bus.w1, bus.w2, bus.w3}         <= '0;
               {bus.w0_n, bus.w1_n, bus.w2_n, bus.w3_n} <= '0;
            end
         endcase
      end
   end

`ifdef KEY_RAIL_CHECK_EN
   logic [127:0] rail_eq;
   assign rail_eq = ~({bus.w0, bus.w1, bus.w2, bus.w3} ^ {bus.w0_n, bus.w1_n, bus.w2_n, bus.w3_n});

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bus.rail_err <= 1'b0;
      else if (bus.kld)
         bus.rail_err <= 1'b0;
      else if (state == EVAL && |rail_eq)
         bus.rail_err <= 1'b1;
   end
`else
   assign bus.rail_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_expand_wddl.sv
// Directed bench for aes_key_expand_wddl using the FIPS-197 appendix key schedules.
module tb_aes_key_expand_wddl;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   aes_key_expand_wddl_if bus ();

   aes_key_expand_wddl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   round;
      logic [127:0] w;
      logic         done;
   } vec_t;

   vec_t tbl [11];

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_zero_rails(input string tag);
      chk({tag, " valid"}, 128'(bus.valid), 128'd0);
      chk({tag, " done"},  128'(bus.done),  128'd0);
      chk({tag, " w"},   {bus.w0, bus.w1, bus.w2, bus.w3},         128'd0);
      chk({tag, " w_n"}, {bus.w0_n, bus.w1_n, bus.w2_n, bus.w3_n}, 128'd0);
   endtask

   task automatic check_idle(input string tag);
      check_zero_rails(tag);
      chk({tag, " round"}, 128'(bus.round), 128'd0);
   endtask

   task automatic check_eval(input string tag, input logic [3:0] r, input logic [127:0] w,
                             input logic d);
      chk({tag, " valid"}, 128'(bus.valid), 128'd1);
      chk({tag, " round"}, 128'(bus.round), 128'(r));
      chk({tag, " done"},  128'(bus.done),  128'(d));
      chk({tag, " w"},   {bus.w0, bus.w1, bus.w2, bus.w3},         w);
      chk({tag, " w_n"}, {bus.w0_n, bus.w1_n, bus.w2_n, bus.w3_n}, ~w);
   endtask

   task automatic load_key(input logic [127:0] k, input logic [127:0] kn, input logic with_next);
      bus.key   = k;
      bus.key_n = kn;
      bus.kld   = 1'b1;
      bus.next  = with_next;
      tick();
      bus.kld   = 1'b0;
      bus.next  = 1'b0;
   endtask

   task automatic advance(input int r);
      bus.next = 1'b1;
      tick();
      bus.next = 1'b0;
      check_zero_rails($sformatf("pre r%0d", r));
      tick();
      check_eval($sformatf("eval r%0d", r), tbl[r].round, tbl[r].w, tbl[r].done);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      tbl[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0};
      tbl[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
      tbl[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b0};
      tbl[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b, 1'b0};
      tbl[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00, 1'b0};
      tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 1'b0};
      tbl[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd, 1'b0};
      tbl[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 1'b0};
      tbl[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f, 1'b0};
      tbl[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e, 1'b0};
      tbl[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};

      rst       = 1'b1;
      bus.kld   = 1'b0;
      bus.next  = 1'b0;
      bus.key   = '0;
      bus.key_n = '0;
      repeat (2) tick();
      check_idle("reset");
      chk("reset rail_err", 128'(bus.rail_err), 128'd0);
      rst = 1'b0;
      tick();
      check_idle("idle");

      bus.next = 1'b1;
      repeat (2) tick();
      bus.next = 1'b0;
      check_idle("idle next");

      // Load latency: PRE at t+1, EVAL round 0 at t+2
      load_key(K1, ~K1, 1'b0);
      check_zero_rails("load pre");
      tick();
      check_eval("load eval", 4'd0, K1, 1'b0);
      chk("load w0_n", 128'(bus.w0_n), 128'h00000000_00000000_00000000_d481eae9);

      for (int r = 1; r <= 10; r++) advance(r);

      bus.next = 1'b1;
      tick();
      bus.next = 1'b0;
      check_eval("r10 next", 4'd10, tbl[10].w, 1'b1);
      tick();
      check_eval("r10 hold", 4'd10, tbl[10].w, 1'b1);

      // next held through PRE must give a single advance only
      load_key(K1, ~K1, 1'b0);
      tick();
      bus.next = 1'b1;
      tick();
      tick();
      bus.next = 1'b0;
      check_eval("pre next a", 4'd1, tbl[1].w, 1'b0);
      tick();
      check_eval("pre next b", 4'd1, tbl[1].w, 1'b0);

      for (int r = 2; r <= 4; r++) advance(r);

      load_key(K2, ~K2, 1'b1);
      check_zero_rails("kld+next pre");
      tick();
      check_eval("kld+next eval", 4'd0, K2, 1'b0);

      bus.next = 1'b1;
      tick();
      bus.next = 1'b0;
      tick();
      check_eval("k2 r1", 4'd1, K2_R1, 1'b0);

      rst = 1'b1;
      #1;
      check_idle("async rst");
      tick();
      rst = 1'b0;
      bus.next = 1'b1;
      repeat (2) tick();
      bus.next = 1'b0;
      tick();
      check_idle("post rst next");

      // Rail fault: key_n bit 0 equal to key bit 0
      load_key(K1, {~K1[127:1], K1[0]}, 1'b0);
      chk("rail pre", 128'(bus.rail_err), 128'd0);
      tick();
      chk("rail eval", 128'(bus.rail_err), 128'd0);
      tick();
`ifdef KEY_RAIL_CHECK_EN
      chk("rail set", 128'(bus.rail_err), 128'd1);
      tick();
      chk("rail sticky", 128'(bus.rail_err), 128'd1);
`else
      chk("rail tied", 128'(bus.rail_err), 128'd0);
`endif
      load_key(K1, ~K1, 1'b0);
      chk("rail clear", 128'(bus.rail_err), 128'd0);
      repeat (2) tick();
      chk("rail clean", 128'(bus.rail_err), 128'd0);
      check_eval("rail reload", 4'd0, K1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
